// File: rtl/bloco_operativo_pkg.sv
// Shared encodings and default sizing for the bloco_operativo datapath.
package bloco_operativo_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_K     = 3;

  typedef enum logic [1:0] {
    SEL_A_X  = 2'd0,
    SEL_A_RX = 2'd1,
    SEL_A_RH = 2'd2,
    SEL_A_RS = 2'd3
  } sel_a_t;

  typedef enum logic [1:0] {
    SEL_B_RX  = 2'd0,
    SEL_B_RH  = 2'd1,
    SEL_B_K   = 2'd2,
    SEL_B_ONE = 2'd3
  } sel_b_t;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'd0,
    ALU_SUB  = 2'd1,
    ALU_MUL  = 2'd2,
    ALU_PASS = 2'd3
  } alu_op_t;

endpackage

// File: rtl/bloco_operativo_ula.sv
// Combinational ALU for bloco_operativo; the overflow output exists only
// when BLOCO_OPERATIVO_OVF_EN is defined.
import bloco_operativo_pkg::*;

module ula #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
`ifdef BLOCO_OPERATIVO_OVF_EN
  output logic             overflow,
`endif
  output logic [WIDTH-1:0] result
);

`ifdef BLOCO_OPERATIVO_OVF_EN
  logic [WIDTH:0]     sum_s;
  logic [WIDTH:0]     diff_s;
  logic [2*WIDTH-1:0] prod_s;

  assign sum_s  = {1'b0, a} + {1'b0, b};
  assign diff_s = {1'b0, a} - {1'b0, b};
  assign prod_s = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  // Result and overflow (carry, borrow, or lost high product bits).
  always_comb begin
    result   = a;
    overflow = 1'b0;
    case (op)
      ALU_ADD: begin
        result   = sum_s[WIDTH-1:0];
        overflow = sum_s[WIDTH];
      end
      ALU_SUB: begin
        result   = diff_s[WIDTH-1:0];
        overflow = diff_s[WIDTH];
      end
      ALU_MUL: begin
        result   = prod_s[WIDTH-1:0];
        overflow = |prod_s[2*WIDTH-1:WIDTH];
      end
      ALU_PASS: begin
        result   = a;
        overflow = 1'b0;
      end
      default: begin
        result   = a;
        overflow = 1'b0;
      end
    endcase
  end
`else
  // Result only, modulo 2^WIDTH.
  always_comb begin
    result = a;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_MUL:  result = a * b;
      ALU_PASS: result = a;
      default:  result = a;
    endcase
  end
`endif

endmodule

// File: rtl/bloco_operativo.sv
// Datapath: operand muxes, ALU, RX/RH/RS registers and held s_out.
// Optional sticky overflow flag enabled by BLOCO_OPERATIVO_OVF_EN.
import bloco_operativo_pkg::*;

module bloco_operativo #(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int K     = DEFAULT_K
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       x_in,
  input  logic             h,
  input  logic             Reg_X,
  input  logic             Reg_H,
  input  logic             Reg_S,
  input  logic [1:0]       m0,
  input  logic [1:0]       m1,
  input  logic [1:0]       m2,
  output logic [WIDTH-1:0] s_out,
  output logic             zero,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] K_C   = WIDTH'(K);
  localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1'b1);

  logic [WIDTH-1:0] rx_r;
  logic [WIDTH-1:0] rh_r;
  logic [WIDTH-1:0] rs_r;
  logic [WIDTH-1:0] op_a_s;
  logic [WIDTH-1:0] op_b_s;
  logic [WIDTH-1:0] alu_s;

  // Operand A select.
  always_comb begin
    op_a_s = WIDTH'(x_in);
    case (m0)
      SEL_A_X:  op_a_s = WIDTH'(x_in);
      SEL_A_RX: op_a_s = rx_r;
      SEL_A_RH: op_a_s = rh_r;
      SEL_A_RS: op_a_s = rs_r;
      default:  op_a_s = WIDTH'(x_in);
    endcase
  end

  // Operand B select.
  always_comb begin
    op_b_s = rx_r;
    case (m1)
      SEL_B_RX:  op_b_s = rx_r;
      SEL_B_RH:  op_b_s = rh_r;
      SEL_B_K:   op_b_s = K_C;
      SEL_B_ONE: op_b_s = ONE_C;
      default:   op_b_s = rx_r;
    endcase
  end

`ifdef BLOCO_OPERATIVO_OVF_EN
  logic alu_ovf_s;
  logic ovf_r;
`endif

  ula #(.WIDTH(WIDTH)) u_ula (
    .a        (op_a_s),
    .b        (op_b_s),
    .op       (m2),
`ifdef BLOCO_OPERATIVO_OVF_EN
    .overflow (alu_ovf_s),
`endif
    .result   (alu_s)
  );

  assign zero = (alu_s == {WIDTH{1'b0}});

  // Working registers and output register; enables are independent.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_r  <= {WIDTH{1'b0}};
      rh_r  <= {WIDTH{1'b0}};
      rs_r  <= {WIDTH{1'b0}};
      s_out <= {WIDTH{1'b0}};
    end else begin
      if (Reg_X) rx_r <= alu_s;
      if (Reg_H) rh_r <= alu_s;
      if (Reg_S) rs_r <= alu_s;
      if (!h) s_out <= rs_r;
    end
  end

`ifdef BLOCO_OPERATIVO_OVF_EN
  // Sticky overflow: set on an overflowing RS load, cleared by an RX load.
  always_ff @(posedge clock) begin
    if (reset) begin
      ovf_r <= 1'b0;
    end else if (Reg_S && alu_ovf_s) begin
      ovf_r <= 1'b1;
    end else if (Reg_X) begin
      ovf_r <= 1'b0;
    end
  end

  assign ovf = ovf_r;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_bloco_operativo.sv
// Table-driven directed bench for bloco_operativo (WIDTH=16, K=3).
module tb_bloco_operativo;

  typedef struct {
    logic        rst;
    logic [7:0]  x;
    logic        hold;
    logic        ex;
    logic        eh;
    logic        es;
    logic [1:0]  s0;
    logic [1:0]  s1;
    logic [1:0]  s2;
    logic        exp_zero;
    logic [15:0] exp_sout;
    logic        exp_ovf;
    string       name;
  } vec_t;

`ifdef BLOCO_OPERATIVO_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic [7:0]  x_in;
  logic        h;
  logic        Reg_X;
  logic        Reg_H;
  logic        Reg_S;
  logic [1:0]  m0;
  logic [1:0]  m1;
  logic [1:0]  m2;
  logic [15:0] s_out;
  logic        zero;
  logic        ovf;

  int n_vec  = 0;
  int n_fail = 0;
  vec_t vecs[$];

  bloco_operativo #(.WIDTH(16), .K(3)) dut (
    .clock (clock),
    .reset (reset),
    .x_in  (x_in),
    .h     (h),
    .Reg_X (Reg_X),
    .Reg_H (Reg_H),
    .Reg_S (Reg_S),
    .m0    (m0),
    .m1    (m1),
    .m2    (m2),
    .s_out (s_out),
    .zero  (zero),
    .ovf   (ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t mk(input logic rst, input logic [7:0] x, input logic hold,
                              input logic ex, input logic eh, input logic es,
                              input logic [1:0] s0, input logic [1:0] s1, input logic [1:0] s2,
                              input logic ez, input logic [15:0] eso, input logic eo,
                              input string nm);
    vec_t v;
    v.rst = rst; v.x = x; v.hold = hold; v.ex = ex; v.eh = eh; v.es = es;
    v.s0 = s0; v.s1 = s1; v.s2 = s2;
    v.exp_zero = ez; v.exp_sout = eso; v.exp_ovf = eo; v.name = nm;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive on the falling edge, check zero before the rising edge, registers after it.
  task automatic apply(input vec_t v);
    @(negedge clock);
    reset = v.rst; x_in = v.x; h = v.hold;
    Reg_X = v.ex; Reg_H = v.eh; Reg_S = v.es;
    m0 = v.s0; m1 = v.s1; m2 = v.s2;
    #1;
    n_vec++;
    chk({v.name, ".zero"}, {15'd0, zero}, {15'd0, v.exp_zero});
    @(posedge clock);
    #1;
    chk({v.name, ".s_out"}, s_out, v.exp_sout);
    chk({v.name, ".ovf"}, {15'd0, ovf}, {15'd0, (OVF_ON ? v.exp_ovf : 1'b0)});
  endtask

  initial begin
    reset = 1'b1; x_in = 8'd0; h = 1'b0;
    Reg_X = 1'b0; Reg_H = 1'b0; Reg_S = 1'b0;
    m0 = 2'd0; m1 = 2'd0; m2 = 2'd0;

    //           rst x      h     X     H     S     m0    m1    m2    zero  s_out      ovf
    vecs.push_back(mk(1'b1, 8'd9, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 2'd0, 2'd3, 1'b0, 16'h0000, 1'b0, "reset"));
    vecs.push_back(mk(1'b0, 8'd5, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd3, 1'b0, 16'h0000, 1'b0, "ld_rx"));
    vecs.push_back(mk(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 2'd3, 1'b0, 16'h0000, 1'b0, "ld_rs"));
    vecs.push_back(mk(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd3, 1'b1, 16'h0005, 1'b0, "sout5"));
    vecs.push_back(mk(1'b0, 8'd4, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd3, 1'b0, 16'h0005, 1'b0, "poly_rx"));
    vecs.push_back(mk(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 2'd0, 2'd2, 1'b0, 16'h0005, 1'b0, "poly_sq"));
    vecs.push_back(mk(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd2, 2'd2, 1'b0, 16'h0005, 1'b0, "poly_k"));
    vecs.push_back(mk(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 2'd0, 2'd0, 1'b0, 16'h0030, 1'b0, "poly_add"));
    vecs.push_back(mk(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0, 2'd3, 1'b0, 16'h0034, 1'b0, "poly_out"));
    vecs.push_back(mk(1'b0, 8'd7, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd3, 1'b0, 16'h0034, 1'b0, "hold_ld"));
    vecs.push_back(mk(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0, 2'd3, 1'b0, 16'h0034, 1'b0, "hold_keep"));
    vecs.push_back(mk(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0, 2'd3, 1'b0, 16'h0007, 1'b0, "hold_rel"));
    vecs.push_back(mk(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd3, 2'd1, 1'b0, 16'h0007, 1'b0, "wrap_rx"));
    vecs.push_back(mk(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 2'd3, 1'b0, 16'h0007, 1'b0, "wrap_rs"));
    vecs.push_back(mk(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 2'd3, 2'd0, 1'b1, 16'hFFFF, 1'b1, "wrap_add"));
    vecs.push_back(mk(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0, 2'd3, 1'b1, 16'h0000, 1'b1, "wrap_out"));
    vecs.push_back(mk(1'b0, 8'd2, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd3, 1'b0, 16'h0000, 1'b0, "ovf_clr"));
    vecs.push_back(mk(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 2'd1, 1'b0, 16'h0000, 1'b1, "set_wins"));
    vecs.push_back(mk(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 2'd1, 2'd2, 1'b0, 16'hFFFE, 1'b1, "mul_rh"));
    vecs.push_back(mk(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd3, 1'b1, 16'hFFFE, 1'b0, "ovf_clr2"));
    vecs.push_back(mk(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd2, 2'd2, 1'b0, 16'hFFFE, 1'b1, "mul_ovf"));
    vecs.push_back(mk(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0, 2'd3, 1'b0, 16'hFFA0, 1'b1, "mul_out"));
    vecs.push_back(mk(1'b0, 8'd9, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 2'd0, 2'd3, 1'b0, 16'hFFA0, 1'b0, "all_ld"));
    vecs.push_back(mk(1'b1, 8'd9, 1'b0, 1'b1, 1'b1, 1'b1, 2'd3, 2'd1, 2'd1, 1'b1, 16'h0000, 1'b0, "all_rst"));
    vecs.push_back(mk(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 2'd3, 1'b1, 16'h0000, 1'b0, "rx_clr"));
    vecs.push_back(mk(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 2'd3, 1'b1, 16'h0000, 1'b0, "rh_clr"));
    vecs.push_back(mk(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0, 2'd3, 1'b1, 16'h0000, 1'b0, "rs_clr"));

    foreach (vecs[i]) apply(vecs[i]);

    // Reset during a hold with the overflow flag set must clear everything.
    apply(mk(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd3, 2'd1, 1'b0, 16'h0000, 1'b1, "seq_sub"));
    apply(mk(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0, 2'd3, 1'b0, 16'hFFFF, 1'b1, "seq_out"));
    apply(mk(1'b1, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 2'd0, 2'd3, 1'b1, 16'h0000, 1'b0, "seq_rst_h"));
    apply(mk(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0, 2'd3, 1'b1, 16'h0000, 1'b0, "seq_after"));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
